icache: RTL and testbench

- Direct-mapped, read-only instruction cache sitting directly upstream of the fetch stage.
- Fetch side: accepts fetch's PC and read strobe; returns the 32-bit instruction with a one-cycle done pulse.
- Memory side: on a miss, refills a whole line from the main-memory port using a request/grant handshake followed by sequential data beats.
- Supports a full invalidate (fence.i / self-modifying code).

---
 rtl/icache_pkg.sv | 37 +++
 rtl/icache_if.sv | 14 +
 rtl/icache_data_array.sv | 34 +++
 rtl/icache.sv | 168 ++++++++++++++++
 tb/tb_icache.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_INSTR_WIDTH   = 32;
    localparam int DEF_NUM_LINES     = 16;
    localparam int DEF_LINE_WORDS    = 4;
    localparam int MAX_ADDR_W        = 64;

    typedef enum logic [1:0] {IDLE, REQ, REFILL, RESP} icache_state_e;
    typedef logic [MAX_ADDR_W-1:0] addr_t;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int aw, input int num_lines, input int line_words);
        return aw - $clog2(num_lines) - $clog2(line_words) - 2;
    endfunction

    function automatic addr_t get_off(input addr_t addr, input int line_words);
        return (addr >> 2) & ((addr_t'(1) << off_bits(line_words)) - addr_t'(1));
    endfunction

    function automatic addr_t get_idx(input addr_t addr, input int line_words, input int num_lines);
        return (addr >> (off_bits(line_words) + 2)) & ((addr_t'(1) << idx_bits(num_lines)) - addr_t'(1));
    endfunction

    function automatic addr_t get_tag(input addr_t addr, input int line_words, input int num_lines);
        return addr >> (off_bits(line_words) + idx_bits(num_lines) + 2);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Line-refill bus between the instruction cache (master) and main memory (slave).
interface icache_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_valid;
    logic [DW-1:0] mem_data;

    modport master (output mem_req, mem_addr, input mem_gnt, mem_valid, mem_data);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_valid, mem_data);
endinterface

// File: rtl/icache_data_array.sv
// Line data and tag storage: synchronous write, asynchronous read. Valid bits live in the parent.
module icache_data_array #(
    parameter int DW         = 32,
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24
) (
    input  logic                          i_clk,
    input  logic                          i_we,
    input  logic [$clog2(NUM_LINES)-1:0]  i_wr_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] i_wr_off,
    input  logic [DW-1:0]                 i_wr_data,
    input  logic                          i_tag_we,
    input  logic [TAG_W-1:0]              i_wr_tag,
    input  logic [$clog2(NUM_LINES)-1:0]  i_rd_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] i_rd_off,
    output logic [DW-1:0]                 o_rd_data,
    output logic [TAG_W-1:0]              o_rd_tag
);

    logic [DW-1:0]    r_data [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0] r_tag  [NUM_LINES];

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_data[i_wr_idx][i_wr_off] <= i_wr_data;
        if (i_tag_we)
            r_tag[i_wr_idx] <= i_wr_tag;
    end

    assign o_rd_data = r_data[i_rd_idx][i_rd_off];
    assign o_rd_tag  = r_tag[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with whole-line refill and full invalidate.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache
    import icache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int INSTR_WIDTH   = DEF_INSTR_WIDTH,
    parameter int NUM_LINES     = DEF_NUM_LINES,
    parameter int LINE_WORDS    = DEF_LINE_WORDS
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [ADDRESS_WIDTH-1:0] i_pc,
    input  logic                     i_instr_rd,
    output logic [INSTR_WIDTH-1:0]   o_instr,
    output logic                     o_icache_done,
    input  logic                     i_flush,
    output logic                     o_busy,
`ifdef ICACHE_STATS_EN
    output logic [31:0]              o_hit_cnt,
    output logic [31:0]              o_miss_cnt,
`endif
    icache_if.master                 mem_if
);

    localparam int OFF_W = off_bits(LINE_WORDS);
    localparam int IDX_W = idx_bits(NUM_LINES);
    localparam int TAG_W = tag_bits(ADDRESS_WIDTH, NUM_LINES, LINE_WORDS);

    icache_state_e            r_state, w_next;
    logic [NUM_LINES-1:0]     r_valid;
    logic                     r_flush_pend;
    logic                     r_hit_done;
    logic [INSTR_WIDTH-1:0]   r_instr;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [IDX_W-1:0]         r_idx;
    logic [OFF_W-1:0]         r_off;
    logic [TAG_W-1:0]         r_tag;
    logic [OFF_W-1:0]         r_cnt;

    logic [IDX_W-1:0]         w_pc_idx, w_rd_idx;
    logic [OFF_W-1:0]         w_pc_off, w_rd_off;
    logic [TAG_W-1:0]         w_pc_tag, w_rd_tag;
    logic [INSTR_WIDTH-1:0]   w_rd_data;
    logic                     w_lookup, w_hit, w_miss, w_beat, w_last, w_flush_any;

    assign w_pc_off = OFF_W'(get_off(addr_t'(i_pc), LINE_WORDS));
    assign w_pc_idx = IDX_W'(get_idx(addr_t'(i_pc), LINE_WORDS, NUM_LINES));
    assign w_pc_tag = TAG_W'(get_tag(addr_t'(i_pc), LINE_WORDS, NUM_LINES));

    // Lookups index by the live PC; once a miss is latched the array is addressed by the saved line.
    assign w_rd_idx = (r_state == IDLE) ? w_pc_idx : r_idx;
    assign w_rd_off = (r_state == IDLE) ? w_pc_off : r_off;

    // The cycle carrying a hit's done pulse ignores the still-held read strobe.
    assign w_lookup    = (r_state == IDLE) && i_instr_rd && !r_hit_done;
    assign w_hit       = w_lookup && !i_flush && r_valid[w_pc_idx] && (w_rd_tag == w_pc_tag);
    assign w_miss      = w_lookup && !w_hit;
    assign w_beat      = (r_state == REFILL) && mem_if.mem_valid;
    assign w_last      = w_beat && (r_cnt == OFF_W'(LINE_WORDS - 1));
    assign w_flush_any = r_flush_pend || i_flush;

    icache_data_array #(
        .DW         (INSTR_WIDTH),
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .i_clk     (i_clk),
        .i_we      (w_beat),
        .i_wr_idx  (r_idx),
        .i_wr_off  (r_cnt),
        .i_wr_data (mem_if.mem_data),
        .i_tag_we  (w_last),
        .i_wr_tag  (r_tag),
        .i_rd_idx  (w_rd_idx),
        .i_rd_off  (w_rd_off),
        .o_rd_data (w_rd_data),
        .o_rd_tag  (w_rd_tag)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_miss) w_next = REQ;
            REQ:     if (mem_if.mem_gnt) w_next = REFILL;
            REFILL:  if (w_last) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_if.mem_req  = (r_state == REQ);
        mem_if.mem_addr = r_mem_addr;
        o_busy          = (r_state != IDLE);
        o_icache_done   = r_hit_done || (r_state == RESP);
        o_instr         = r_instr;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_hit_done   <= 1'b0;
            r_instr      <= '0;
            r_mem_addr   <= '0;
            r_idx        <= '0;
            r_off        <= '0;
            r_tag        <= '0;
            r_cnt        <= '0;
        end else begin
            r_hit_done <= w_hit;
            if (w_hit)
                r_instr <= w_rd_data;
            if (w_miss) begin
                r_idx      <= w_pc_idx;
                r_off      <= w_pc_off;
                r_tag      <= w_pc_tag;
                r_mem_addr <= {w_pc_tag, w_pc_idx, {(OFF_W + 2){1'b0}}};
            end
            if (r_state == REQ && mem_if.mem_gnt)
                r_cnt <= '0;
            else if (w_beat)
                r_cnt <= r_cnt + OFF_W'(1);
            // The requested word may be the one arriving on the last beat, not yet in the array.
            if (w_last)
                r_instr <= (r_off == r_cnt) ? mem_if.mem_data : w_rd_data;
            if (r_state == IDLE && i_flush)
                r_valid <= '0;
            else if (r_state == RESP && w_flush_any)
                r_valid <= '0;
            else if (w_last && !w_flush_any)
                r_valid[r_idx] <= 1'b1;
            if (r_state == RESP)
                r_flush_pend <= 1'b0;
            else if (r_state != IDLE && i_flush)
                r_flush_pend <= 1'b1;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss && r_miss_cnt != '1)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, conflict, flush mid-refill, reset mid-refill, stalled memory.
module tb_icache;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_pc;
    logic        i_instr_rd;
    logic [31:0] o_instr;
    logic        o_icache_done;
    logic        i_flush;
    logic        o_busy;
`ifdef ICACHE_STATS_EN
    logic [31:0] o_hit_cnt, o_miss_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    icache_if #(.AW(32), .DW(32)) mem_if ();

    icache dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pc          (i_pc),
        .i_instr_rd    (i_instr_rd),
        .o_instr       (o_instr),
        .o_icache_done (o_icache_done),
        .i_flush       (i_flush),
        .o_busy        (o_busy),
`ifdef ICACHE_STATS_EN
        .o_hit_cnt     (o_hit_cnt),
        .o_miss_cnt    (o_miss_cnt),
`endif
        .mem_if        (mem_if)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_done"}, 32'(o_icache_done), 32'd0);
        chk({tag, "_req"},  32'(mem_if.mem_req), 32'd0);
        chk({tag, "_addr"}, mem_if.mem_addr, 32'd0);
        chk({tag, "_instr"}, o_instr, 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    // Full miss: request, optional grant delay, four beats (optional gap before beat 2, optional flush on a beat).
    task automatic miss_seq(input logic [31:0] pc, input logic [31:0] base, input int gnt_dly,
                            input int gap, input int flush_beat, input bit flush_at_lookup);
        logic [31:0] exp_word;
        exp_word = base + 32'(pc[3:2]);
        i_pc = pc;
        i_instr_rd = 1'b1;
        if (flush_at_lookup) i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("miss_req", 32'(mem_if.mem_req), 32'd1);
        chk("miss_addr", mem_if.mem_addr, pc & 32'hFFFF_FFF0);
        chk("miss_busy", 32'(o_busy), 32'd1);
        for (int i = 0; i < gnt_dly; i++) begin
            step();
            chk("req_hold", 32'(mem_if.mem_req), 32'd1);
        end
        mem_if.mem_gnt = 1'b1;
        step();
        mem_if.mem_gnt = 1'b0;
        chk("req_drop", 32'(mem_if.mem_req), 32'd0);
        for (int w = 0; w < 4; w++) begin
            if (w == 2) begin
                for (int g = 0; g < gap; g++) begin
                    mem_if.mem_valid = 1'b0;
                    step();
                    chk("gap_nodone", 32'(o_icache_done), 32'd0);
                end
            end
            mem_if.mem_valid = 1'b1;
            mem_if.mem_data  = base + 32'(w);
            if (w == flush_beat) i_flush = 1'b1;
            step();
            i_flush = 1'b0;
        end
        mem_if.mem_valid = 1'b0;
        mem_if.mem_data  = 32'hDEAD_BEEF;
        chk("resp_done", 32'(o_icache_done), 32'd1);
        chk("resp_instr", o_instr, exp_word);
        i_instr_rd = 1'b0;
        step();
        chk("post_done", 32'(o_icache_done), 32'd0);
        chk("post_busy", 32'(o_busy), 32'd0);
        chk("post_instr_hold", o_instr, exp_word);
    endtask

    task automatic hit_seq(input logic [31:0] pc, input logic [31:0] exp);
        i_pc = pc;
        i_instr_rd = 1'b1;
        step();
        chk("hit_done", 32'(o_icache_done), 32'd1);
        chk("hit_instr", o_instr, exp);
        chk("hit_noreq", 32'(mem_if.mem_req), 32'd0);
        chk("hit_busy", 32'(o_busy), 32'd0);
        step();
        chk("hit_rearm", 32'(o_icache_done), 32'd0);
        i_instr_rd = 1'b0;
        step();
    endtask

    initial begin
        i_rst = 1'b1;
        i_pc = '0;
        i_instr_rd = 1'b0;
        i_flush = 1'b0;
        mem_if.mem_gnt = 1'b0;
        mem_if.mem_valid = 1'b0;
        mem_if.mem_data = '0;
        #1 i_rst = 1'b0;
        step();
        check_idle_zero("rst");
        step();
        i_rst = 1'b1;
        step();

        // cold miss, then hits in the same line
        miss_seq(32'h100, 32'hA0, 0, 0, -1, 1'b0);
        hit_seq(32'h10C, 32'hA3);
        hit_seq(32'h104, 32'hA1);

        // conflict on index 0
        miss_seq(32'h200, 32'hB0, 0, 0, -1, 1'b0);
        hit_seq(32'h208, 32'hB2);
        miss_seq(32'h100, 32'hA0, 1, 0, -1, 1'b0);

        // flush during beat 2: data still returned, line not kept, other lines dropped too
        miss_seq(32'h140, 32'hC0, 0, 0, 2, 1'b0);
        miss_seq(32'h140, 32'hC0, 0, 0, -1, 1'b0);
        miss_seq(32'h100, 32'hA0, 0, 0, -1, 1'b0);
        hit_seq(32'h144, 32'hC1);

        // flush in IDLE with a simultaneous lookup is a miss
        miss_seq(32'h144, 32'hC0, 0, 0, -1, 1'b1);

        // memory beats outside REFILL are ignored
        mem_if.mem_valid = 1'b1;
        mem_if.mem_data = 32'h5555_5555;
        step();
        chk("stray_busy", 32'(o_busy), 32'd0);
        mem_if.mem_valid = 1'b0;
        hit_seq(32'h148, 32'hC2);

        // reset in the middle of a refill
        i_pc = 32'h300;
        i_instr_rd = 1'b1;
        step();
        mem_if.mem_gnt = 1'b1;
        step();
        mem_if.mem_gnt = 1'b0;
        for (int w = 0; w < 2; w++) begin
            mem_if.mem_valid = 1'b1;
            mem_if.mem_data = 32'hD0 + 32'(w);
            step();
        end
        chk("mid_busy", 32'(o_busy), 32'd1);
        mem_if.mem_valid = 1'b0;
        i_instr_rd = 1'b0;
        i_rst = 1'b0;
        #1;
        check_idle_zero("midrst");
        step();
        i_rst = 1'b1;
        step();
        miss_seq(32'h300, 32'hD0, 0, 0, -1, 1'b0);
        miss_seq(32'h140, 32'hC0, 0, 0, -1, 1'b0);

        // clean reset so the counters start from zero, then stalled grant and gapped beats
        i_rst = 1'b0;
        step();
        i_rst = 1'b1;
        step();
        miss_seq(32'h34C, 32'hE0, 5, 3, -1, 1'b0);
        hit_seq(32'h344, 32'hE1);
`ifdef ICACHE_STATS_EN
        chk("stat_miss", o_miss_cnt, 32'd1);
        chk("stat_hit", o_hit_cnt, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
